// File: rtl/ones_pattern_gen_pkg.sv
// Shared definitions for the fixed-weight pattern enumerator.
package ones_pattern_gen_pkg;

    // Default pattern width.
    localparam int DEFAULT_W = 8;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EMIT   = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/ones_pattern_gen_next.sv
// Combinational successor: the next larger W-bit value with the same popcount
// (Gosper's hack). Arithmetic runs one bit wider than the pattern so the carry
// out of x + c lands in a spare bit instead of wrapping into the result.
module ones_next_pattern
    import ones_pattern_gen_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] next
);

    localparam int XW = W + 1;
    localparam int SW = $clog2(XW);

    logic [XW-1:0] xe;
    logic [XW-1:0] c;
    logic [XW-1:0] r;
    logic [XW-1:0] diff;
    logic [XW-1:0] sum;
    logic [SW-1:0] shamt;

    // Lowest set bit, ripple sum, and the shifted-down tail of moved bits.
    always_comb begin
        xe    = {1'b0, x};
        c     = xe & (~xe + XW'(1));
        r     = xe + c;
        shamt = '0;
        // c is a single bit (or zero); its position is log2(c).
        for (int i = 0; i < XW; i++) begin
            if (c[i]) begin
                shamt = SW'(i);
            end
        end
        diff = (r ^ xe) >> 2;
        diff = diff >> shamt;
        sum  = diff | r;
        next = sum[W-1:0];
    end

endmodule

// File: rtl/ones_pattern_gen.sv
// Enumerates every W-bit value with a requested number of ones, in ascending
// order, over a valid/ready stream. First pattern appears one cycle after an
// accepted start; done pulses in the cycle after the final handshake.
module ones_pattern_gen
    import ones_pattern_gen_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [$clog2(W+1)-1:0]   weight,
    output logic [W-1:0]             pat,
    output logic                     pat_valid,
    input  logic                     pat_ready,
    output logic                     pat_last,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int WW = $clog2(W + 1);

    state_t          state_reg, state_next;
    logic [W-1:0]    pat_reg, pat_next;
    logic [WW-1:0]   weight_reg, weight_next;
    logic            valid_reg, valid_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
    logic            err_reg, err_next;

    logic [W-1:0]    init_pat;
    logic [W-1:0]    top_pat;
    logic [W-1:0]    gosper_pat;
    logic [WW-1:0]   top_base;
    logic            weight_bad;
    logic            last_now;
    logic            handshake;

    // Top pattern has ones in bit positions >= W - weight.
    assign top_base   = WW'(W) - weight_reg;
    assign weight_bad = (weight > WW'(W));

    // First pattern is the low `weight` bits set; last is the high `weight` bits.
    for (genvar gi = 0; gi < W; gi++) begin : g_masks
        assign init_pat[gi] = (WW'(gi) < weight);
        assign top_pat[gi]  = (WW'(gi) >= top_base);
    end

    ones_next_pattern #(
        .W (W)
    ) u_next (
        .x    (pat_reg),
        .next (gosper_pat)
    );

    assign last_now  = valid_reg && (pat_reg == top_pat);
    assign handshake = valid_reg && pat_ready;

    assign pat       = pat_reg;
    assign pat_valid = valid_reg;
    assign pat_last  = last_now;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;

    // Next-state and next-output logic; everything is held unless changed below.
    always_comb begin
        state_next  = state_reg;
        pat_next    = pat_reg;
        weight_next = weight_reg;
        valid_next  = valid_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;
        err_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (weight_bad) begin
                        err_next = 1'b1;
                    end else begin
                        state_next  = EMIT;
                        weight_next = weight;
                        pat_next    = init_pat;
                        valid_next  = 1'b1;
                        busy_next   = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (handshake) begin
                    if (last_now) begin
                        state_next = FINISH;
                        valid_next = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        pat_next = gosper_pat;
                    end
                end
            end
            FINISH: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            pat_reg    <= '0;
            weight_reg <= '0;
            valid_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pat_reg    <= pat_next;
            weight_reg <= weight_next;
            valid_reg  <= valid_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
        end
    end

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Directed bench for ones_pattern_gen (W = 8): full enumerations at several
// weights, stalls, ignored restarts, bad weight, and reset mid-run.
module tb_ones_pattern_gen;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] weight;
    logic [7:0] pat;
    logic       pat_valid;
    logic       pat_ready;
    logic       pat_last;
    logic       busy;
    logic       done;
    logic       err;

    int tests = 0;
    int fails = 0;

    ones_pattern_gen #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .weight    (weight),
        .pat       (pat),
        .pat_valid (pat_valid),
        .pat_ready (pat_ready),
        .pat_last  (pat_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_pat"},   32'(pat),       0);
        check({tag, "_valid"}, 32'(pat_valid), 0);
        check({tag, "_last"},  32'(pat_last),  0);
        check({tag, "_busy"},  32'(busy),      0);
        check({tag, "_done"},  32'(done),      0);
        check({tag, "_err"},   32'(err),       0);
    endtask

    // One enumeration run. Expected list comes from a brute-force popcount scan.
    // rnd: random pat_ready; poke: pulse start (with an illegal weight) mid-run;
    // abort_at: if nonzero, assert reset after that many handshakes.
    task automatic run(input int w, input bit rnd, input bit poke, input int abort_at);
        logic [7:0] exp_q[$];
        logic [7:0] held;
        int         n;
        int         stop_at;
        int         idx;
        int         cyc;
        bit         stalled;
        bit         poked;
        for (int v = 0; v < 256; v++) begin
            if ($countones(8'(v)) == w) exp_q.push_back(8'(v));
        end
        n       = exp_q.size();
        stop_at = (abort_at != 0) ? abort_at : n;
        pat_ready = 1'b0;
        start     = 1'b1;
        weight    = 4'(w);
        @(negedge clk);
        start = 1'b0;
        check("valid_latency", 32'(pat_valid), 1);
        check("busy_on",       32'(busy),      1);
        idx = 0; cyc = 0; stalled = 1'b0; poked = 1'b0;
        while (idx < stop_at && cyc < 2000) begin
            start = 1'b0;
            if (stalled) begin
                check("stall_hold_pat",  32'(pat),       32'(held));
                check("stall_hold_last", 32'(pat_last),  32'(idx == n - 1));
            end
            check("valid_in_run", 32'(pat_valid), 1);
            check("err_quiet",    32'(err),       0);
            if (poke && !poked && idx == 5) begin
                start  = 1'b1;
                weight = 4'd9;
                poked  = 1'b1;
            end
            pat_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pat_ready) begin
                check("pat_value",    32'(pat),             32'(exp_q[idx]));
                check("pat_popcount", $countones(pat),      w);
                check("pat_last",     32'(pat_last),        32'(idx == n - 1));
                $display("[TB] w=%0d #%0d pat=%02h last=%0b", w, idx, pat, pat_last);
                idx++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held    = pat;
            end
            @(negedge clk);
            cyc++;
        end
        start     = 1'b0;
        pat_ready = 1'b0;
        check("run_complete", idx, stop_at);
        if (abort_at != 0) begin
            rst_n = 1'b0;
            #1;
            check_idle_outputs("async_reset");
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            check_idle_outputs("post_reset_wait");
        end else begin
            check("done_pulse",  32'(done),      1);
            check("valid_drop",  32'(pat_valid), 0);
            check("last_drop",   32'(pat_last),  0);
            check("busy_finish", 32'(busy),      1);
            @(negedge clk);
            check("done_once",   32'(done),      0);
            check("busy_off",    32'(busy),      0);
            check("valid_idle",  32'(pat_valid), 0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        weight    = 4'd0;
        pat_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_state");
        rst_n = 1'b1;
        @(negedge clk);

        // weight 2, always ready: 28 patterns 0x03 .. 0xC0
        run(2, 1'b0, 1'b0, 0);
        // weight 4, random backpressure: 70 patterns
        run(4, 1'b1, 1'b0, 0);
        // single-pattern edge weights
        run(0, 1'b0, 1'b0, 0);
        run(8, 1'b1, 1'b0, 0);

        // weight 9 is illegal: err pulse only
        start  = 1'b1;
        weight = 4'd9;
        @(negedge clk);
        start = 1'b0;
        check("bad_err",   32'(err),       1);
        check("bad_valid", 32'(pat_valid), 0);
        check("bad_busy",  32'(busy),      0);
        @(negedge clk);
        check("bad_err_once", 32'(err),       0);
        check("bad_valid2",   32'(pat_valid), 0);
        check("bad_busy2",    32'(busy),      0);
        $display("[TB] w=9 rejected err pulse seen");

        // weight 3 with a start pulse mid-run: 56 patterns, no err
        run(3, 1'b1, 1'b1, 0);
        // weight 3 aborted by reset after 10 patterns, then weight 1
        run(3, 1'b0, 1'b0, 10);
        run(1, 1'b0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ones_pattern_gen.md
ONES_PATTERN_GEN -- requirements
Module: ones_pattern_gen

Interface
REQ-001 SHALL have parameter: W, 8, pattern width in bits (legal values 2..16).
REQ-002 SHALL have port: clk  input  1  rising-edge system clock.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port: start  input  1  request enumeration for the given weight.
REQ-005 SHALL have port: weight  input  $clog2(W+1)  number of ones per pattern, sampled on accepted start.
REQ-006 SHALL have port: pat  output  W  current pattern.
REQ-007 SHALL have port: pat_valid  output  1  pat holds a valid pattern.
REQ-008 SHALL have port: pat_ready  input  1  consumer accepts pat when high with pat_valid.
REQ-009 SHALL have port: pat_last  output  1  current pat is the final pattern of the run.
REQ-010 SHALL have port: busy  output  1  enumeration in progress.
REQ-011 SHALL have port: done  output  1  one-cycle pulse after the last handshake.
REQ-012 SHALL have port: err  output  1  one-cycle pulse when start carries weight > W.

Function
REQ-013 SHALL be the inverse of the ones counter: emit every W-bit value whose popcount equals weight, each exactly once, in strictly ascending numeric order.
REQ-014 SHALL use an FSM with states IDLE, EMIT, FINISH.
REQ-015 IDLE: start with weight <= W -> EMIT; latch weight; load pat = (1<<weight)-1; busy=1.
REQ-016 IDLE: start with weight > W -> stay IDLE; err=1 for one cycle; no pattern emitted.
REQ-017 SHALL assert pat_valid in the cycle after start is accepted (latency 1).
REQ-018 EMIT: handshake = pat_valid & pat_ready; on handshake with pat_last=0, advance pat to next value (Gosper step: c=x&-x, r=x+c, next=(((r^x)>>2)>>log2(c))|r) in the following cycle, pat_valid remaining high.
REQ-019 SHALL hold pat, pat_valid, pat_last stable while pat_valid=1 and pat_ready=0.
REQ-020 SHALL assert pat_last iff pat equals the top-weight pattern (all ones in the weight MSBs).
REQ-021 EMIT: handshake with pat_last=1 -> FINISH; pat_valid=0 next cycle.
REQ-022 FINISH: done=1 for exactly one cycle, busy=0 from next cycle, -> IDLE.
REQ-023 weight=0 SHALL emit exactly one pattern, all zeros, with pat_last=1; weight=W SHALL emit exactly one pattern, all ones, with pat_last=1.
REQ-024 SHALL ignore start while busy=1 (no restart, no err).
REQ-025 Gosper arithmetic SHALL use W+1 bits internally so the carry out of r never corrupts pat.
REQ-026 Total patterns per run SHALL equal C(W,weight).

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, pat=0, pat_valid=0, pat_last=0, busy=0, done=0, err=0.
REQ-028 Reset mid-run SHALL abort the enumeration; after release the block waits for a new start.
REQ-029 The first start accepted SHALL be on the first rising clk edge with rst_n high.

Structure
REQ-030 Shared package SHALL hold the FSM state enum (IDLE, EMIT, FINISH) and the default width constant.
REQ-031 Next-pattern computation SHALL be a combinational sub-module ones_next_pattern (in: x[W-1:0]; out: next[W-1:0]).
REQ-032 All registers SHALL be in the top module; one clock domain only.

Verification
REQ-033 weight=2, pat_ready=1 constantly -> 28 patterns 0x03,0x05,0x06,0x09,...,0xC0; pat_last on 0xC0; done one cycle later.
REQ-034 weight=4, random pat_ready -> 70 unique ascending patterns, each with popcount 4 (checked via the ones counter), pat stable during stalls.
REQ-035 weight=0 -> single 0x00 with pat_last=1; weight=8 -> single 0xFF with pat_last=1.
REQ-036 weight=9 -> err pulse, pat_valid stays 0, busy stays 0.
REQ-037 start pulsed again during weight=3 run -> ignored; run completes 56 patterns.
REQ-038 rst_n low after 10th pattern of weight=3 run -> outputs zero immediately; new start with weight=1 -> 0x01,0x02,...,0x80.
